// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// Optional saturating stall counter is built when PIPE_STAGE_REG_STALL_CNT_EN is defined.
module pipe_stage_reg #(
    parameter int                 WIDTH     = 64,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [WIDTH-1:0]  r_main;
    logic [WIDTH-1:0]  r_skid;
    logic              w_accept;
    logic              w_drain;
    logic              w_load_m_in;
    logic              w_load_m_skid;
    logic              w_load_s;

    // Handshake: a beat transfers on an edge where valid and ready are both high.
    // in_ready/out_valid decode from state only, so no combinational ready path exists.
    assign out_valid = (r_state != ST_EMPTY);
    assign in_ready  = (r_state != ST_SKID);
    assign out_data  = r_main;
    assign dbg_state = r_state;

    assign w_accept = in_valid & in_ready;
    assign w_drain  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_load_m_in   = 1'b0;
        w_load_m_skid = 1'b0;
        w_load_s      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_load_m_in  = 1'b1;
                    w_next_state = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_accept && w_drain) begin
                    w_load_m_in = 1'b1;
                end else if (w_accept) begin
                    w_load_s     = 1'b1;
                    w_next_state = ST_SKID;
                end else if (w_drain) begin
                    w_next_state = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (w_drain) begin
                    w_load_m_skid = 1'b1;
                    w_next_state  = ST_FULL;
                end
            end
            default: w_next_state = ST_EMPTY;
        endcase
        // Squash discards any same-cycle accept and leaves the data registers untouched.
        if (flush) begin
            w_next_state  = ST_EMPTY;
            w_load_m_in   = 1'b0;
            w_load_m_skid = 1'b0;
            w_load_s      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_main <= RESET_VAL;
            r_skid <= RESET_VAL;
        end else begin
            if (w_load_m_in) begin
                r_main <= in_data;
            end else if (w_load_m_skid) begin
                r_main <= r_skid;
            end
            if (w_load_s) begin
                r_skid <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule
